// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with registered or first-word-fall-through read, exact
// occupancy, programmable almost-full/almost-empty thresholds and sticky error flags.
module sync_fifo_ext #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned PTR       = 4,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AFULL_TH  = 12,
  parameter int unsigned AEMPTY_TH = 2,
  parameter int unsigned FWFT      = 0
) (
  input  logic             clk,
  input  logic             reset_,
  input  logic             wren,
  input  logic [WIDTH-1:0] datain,
  input  logic             rden,
  input  logic             clr_err,
  output logic [WIDTH-1:0] dataout,
  output logic             wrfull,
  output logic             rdempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [PTR:0]     usedw,
  output logic             ovf,
  output logic             udf
);

  localparam int unsigned UW = PTR + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR-1:0]   rd_ptr_q, rd_ptr_d;
  logic [UW-1:0]    usedw_q, usedw_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic [WIDTH-1:0] dataout_q, dataout_d;
  logic             rd_acc, wr_acc;

  // All status flags decode the registered occupancy only.
  assign wrfull       = (usedw_q == UW'(DEPTH));
  assign rdempty      = (usedw_q == '0);
  assign almost_full  = (usedw_q >= UW'(AFULL_TH));
  assign almost_empty = (usedw_q <= UW'(AEMPTY_TH));
  assign usedw        = usedw_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;
  assign dataout      = dataout_q;

  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    dataout_d = dataout_q;

    rd_acc = rden & ~rdempty;
    wr_acc = wren & (~wrfull | rd_acc);

    if (wr_acc) begin
      mem_d[wr_ptr_q] = datain;
      wr_ptr_d        = wr_ptr_q + PTR'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR'(1);
    end

    usedw_d = usedw_q + UW'(wr_acc) - UW'(rd_acc);

    // Error set takes priority over clear in the same cycle.
    ovf_d = (wren & ~wr_acc) | (ovf_q & ~clr_err);
    udf_d = (rden & ~rd_acc) | (udf_q & ~clr_err);

    // FWFT presents the next head (including a word written this edge); when the
    // FIFO drains, the last popped word is held. Full-rate read+write never aliases
    // because the head has already advanced past the rewritten slot.
    if (FWFT != 0) begin
      if (usedw_d != '0) begin
        dataout_d = mem_d[rd_ptr_d];
      end
    end else if (rd_acc) begin
      dataout_d = mem_q[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      usedw_q   <= '0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
      dataout_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      usedw_q   <= usedw_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
      dataout_q <= dataout_d;
    end
  end

  // Storage is not reset, but a reset cycle must not write.
  always_ff @(posedge clk) begin
    if (reset_) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_sync_fifo_ext.sv
// Self-checking bench: a standard-read and an FWFT instance share stimulus and are
// compared against a queue model, a read-data scoreboard and a table of vectors.
module tb_sync_fifo_ext;

  logic       clk = 1'b0;
  logic       reset_;
  logic       wren, rden, clr_err;
  logic [7:0] datain;

  logic [7:0] dout_s, dout_f;
  logic       wrfull_s, rdempty_s, af_s, ae_s, ovf_s, udf_s;
  logic       wrfull_f, rdempty_f, af_f, ae_f, ovf_f, udf_f;
  logic [4:0] usedw_s, usedw_f;

  always #5 clk = ~clk;

  sync_fifo_ext #(.WIDTH(8), .PTR(4), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(0)) u_std (
    .clk(clk), .reset_(reset_), .wren(wren), .datain(datain), .rden(rden), .clr_err(clr_err),
    .dataout(dout_s), .wrfull(wrfull_s), .rdempty(rdempty_s), .almost_full(af_s),
    .almost_empty(ae_s), .usedw(usedw_s), .ovf(ovf_s), .udf(udf_s));

  sync_fifo_ext #(.WIDTH(8), .PTR(4), .DEPTH(16), .AFULL_TH(12), .AEMPTY_TH(2), .FWFT(1)) u_fwft (
    .clk(clk), .reset_(reset_), .wren(wren), .datain(datain), .rden(rden), .clr_err(clr_err),
    .dataout(dout_f), .wrfull(wrfull_f), .rdempty(rdempty_f), .almost_full(af_f),
    .almost_empty(ae_f), .usedw(usedw_f), .ovf(ovf_f), .udf(udf_f));

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       c;
    logic       rn;
    int         exp_used;
    logic       exp_ovf;
    logic       exp_udf;
  } vec_t;

  vec_t       tbl[$];
  logic [7:0] mq[$];
  logic [7:0] sb[$];
  logic [7:0] m_dout, m_last;
  logic       m_ovf, m_udf;
  int         n_vec = 0;
  int         n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: drive, advance the model, then sample #1 after the edge.
  task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c,
                     input logic rn);
    logic ra, wa, popped;
    reset_ = rn; wren = w; datain = d; rden = r; clr_err = c;
    popped = 1'b0;
    if (!rn) begin
      mq.delete(); sb.delete();
      m_ovf = 1'b0; m_udf = 1'b0; m_dout = 8'h00; m_last = 8'h00;
    end else begin
      ra = r && (mq.size() > 0);
      wa = w && ((mq.size() < 16) || ra);
      if (ra) begin
        m_last = mq.pop_front();
        sb.push_back(m_last);
        popped = 1'b1;
      end
      if (wa) mq.push_back(d);
      m_ovf = (w && !wa) ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = (r && !ra) ? 1'b1 : (c ? 1'b0 : m_udf);
    end
    @(posedge clk);
    #1;
    if (popped) m_dout = sb.pop_front();
    chk("usedw",        32'(usedw_s),  32'(mq.size()));
    chk("wrfull",       32'(wrfull_s), 32'(mq.size() == 16));
    chk("rdempty",      32'(rdempty_s), 32'(mq.size() == 0));
    chk("almost_full",  32'(af_s),     32'(mq.size() >= 12));
    chk("almost_empty", 32'(ae_s),     32'(mq.size() <= 2));
    chk("ovf",          32'(ovf_s),    32'(m_ovf));
    chk("udf",          32'(udf_s),    32'(m_udf));
    chk("dataout_std",  32'(dout_s),   32'(m_dout));
    chk("dataout_fwft", 32'(dout_f),   32'((mq.size() > 0) ? mq[0] : m_last));
    chk("usedw_fwft",   32'(usedw_f),  32'(mq.size()));
  endtask

  initial begin
    int wc, rc, budget;
    logic w, r;
    logic [7:0] d;

    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0});
    for (int i = 1; i <= 16; i++) tbl.push_back('{1'b1, 8'(i), 1'b0, 1'b0, 1'b1, i, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 16, 1'b1, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h55, 1'b1, 1'b0, 1'b1, 16, 1'b0, 1'b0});
    for (int i = 15; i >= 0; i--) tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, i, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0});

    reset_ = 1'b0; wren = 1'b0; rden = 1'b0; clr_err = 1'b0; datain = 8'h00;
    m_dout = 8'h00; m_last = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;

    foreach (tbl[i]) begin
      cyc(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].rn);
      chk("tbl_usedw", 32'(usedw_s), 32'(tbl[i].exp_used));
      chk("tbl_ovf",   32'(ovf_s),   32'(tbl[i].exp_ovf));
      chk("tbl_udf",   32'(udf_s),   32'(tbl[i].exp_udf));
    end
    // Standard read of the 0x33 word landed one cycle after its rden edge.
    chk("seq_33_std", 32'(dout_s), 32'h33);

    // Random interleave: 20 words in and out, pointers wrap past DEPTH.
    wc = 0; rc = 0; budget = 0;
    while ((wc < 20 || rc < 20) && budget < 600) begin
      w = (wc < 20) && ($urandom_range(0, 3) != 0);
      r = (rc < 20) && ($urandom_range(0, 2) == 0) && (wc > 6 || wc == 20);
      d = 8'($urandom);
      if (r && mq.size() > 0) rc++;
      if (w && (mq.size() < 16 || (r && mq.size() > 0))) wc++;
      cyc(w, d, r, 1'b0, 1'b1);
      budget++;
    end
    chk("rand_budget", 32'(wc + rc), 32'd40);
    chk("rand_drained", 32'(usedw_s), 32'd0);

    // Reset mid-operation with a concurrent write request.
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    chk("rst_usedw", 32'(usedw_s), 32'd0);
    chk("rst_dout",  32'(dout_s),  32'd0);
    chk("rst_dout_fwft", 32'(dout_f), 32'd0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("rst_nothing_written", 32'(rdempty_s), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
